// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM encoding and the IF/ID latch record.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        HOLD   = 2'b01,
        HALTED = 2'b10
    } fetch_state_t;

    localparam word_t WORD_BYTES = 32'd4;

    // Contents of the IF/ID pipeline latch
    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t npc;
        logic  valid;
    } fd_t;

    // Sequential successor, 32-bit modulo (FFFF_FFFC wraps to 0)
    function automatic word_t next_pc(input word_t pc);
        return pc + WORD_BYTES;
    endfunction

    // Word-align a branch/jump target
    function automatic word_t align_pc(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline latch. Flush and bubble both turn the latch into a NOP
// while keeping the last pc/npc, so debug still shows where the bubble sits.
module if_id_latch
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  en,
    input  logic  flush,
    input  logic  bubble,
    input  word_t instr_in,
    input  word_t pc_in,
    output fd_t   fd
);

    // Latch register: kill beats load, load beats hold
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fd <= '0;
        end else if (flush || bubble) begin
            fd.instr <= '0;
            fd.valid <= 1'b0;
        end else if (en) begin
            fd.instr <= instr_in;
            fd.pc    <= pc_in;
            fd.npc   <= next_pc(pc_in);
            fd.valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one-entry skid buffer and FETCH/HOLD/HALTED FSM
// feeding the IF/ID latch.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] imemaddr,
    input  logic        FDen,
    input  logic        FDflush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] fd_instr,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_npc,
    output logic        fd_valid,
    output logic [1:0]  fetch_state
);

    fetch_state_t state, state_nxt;
    word_t        pc, pc_nxt;
    word_t        buf_instr, buf_pc;
    fd_t          fd;

    logic  avail;      // an instruction could be handed to IF/ID this cycle
    logic  take;       // ... and it survives redirect/halt
    logic  capture;    // park the icache word because IF/ID is stalled
    logic  bubble;
    word_t src_instr, src_pc;

    // Transfer qualification and source select (buffer when in HOLD)
    always_comb begin
        avail     = ((state == FETCH) && ihit) || (state == HOLD);
        take      = avail && !redirect && !halt;
        capture   = (state == FETCH) && ihit && !FDen && !redirect && !halt;
        bubble    = halt || (FDen && !take);
        src_instr = (state == HOLD) ? buf_instr : imemload;
        src_pc    = (state == HOLD) ? buf_pc    : pc;
    end

    // Next-state and next-PC; halt > redirect > normal flow.
    // A word consumed by IF/ID while FDflush is high is squashed, not refetched.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            FETCH: begin
                if (halt) begin
                    state_nxt = HALTED;
                end else if (redirect) begin
                    pc_nxt = align_pc(redirect_pc);
                end else if (ihit) begin
                    pc_nxt = next_pc(pc);
                    if (!FDen) state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (halt) begin
                    state_nxt = HALTED;
                end else if (redirect) begin
                    pc_nxt    = align_pc(redirect_pc);
                    state_nxt = FETCH;
                end else if (FDen) begin
                    state_nxt = FETCH;
                end
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = FETCH;
        endcase
    end

    // FSM and PC registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FETCH;
            pc    <= PC_INIT;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Skid buffer; validity is implied by state == HOLD
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            buf_instr <= '0;
            buf_pc    <= '0;
        end else if (capture) begin
            buf_instr <= imemload;
            buf_pc    <= pc;
        end
    end

    if_id_latch u_fd (
        .CLK      (CLK),
        .nRST     (nRST),
        .en       (FDen),
        .flush    (FDflush),
        .bubble   (bubble),
        .instr_in (src_instr),
        .pc_in    (src_pc),
        .fd       (fd)
    );

    assign iREN        = (state == FETCH);
    assign imemaddr    = pc;
    assign fetch_state = state;
    assign fd_instr    = fd.instr;
    assign fd_pc       = fd.pc;
    assign fd_npc      = fd.npc;
    assign fd_valid    = fd.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic,
// compared against a queue-based behavioural model.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    localparam logic [31:0] PCI = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        nRST, ihit, iREN, FDen, FDflush, redirect, halt, fd_valid;
    logic [31:0] imemload, imemaddr, redirect_pc, fd_instr, fd_pc, fd_npc;
    logic [1:0]  fetch_state;

    always #5 CLK = ~CLK;

    fetch_stage #(.PC_INIT(PCI)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .iREN(iREN), .imemaddr(imemaddr), .FDen(FDen), .FDflush(FDflush),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .fd_instr(fd_instr), .fd_pc(fd_pc), .fd_npc(fd_npc),
        .fd_valid(fd_valid), .fetch_state(fetch_state)
    );

    // Reference model: pc, a pending-word queue (max 1), halted flag, latch
    logic [31:0] m_pc, m_instr, m_fpc, m_npc;
    logic        m_valid, m_halted;
    logic [63:0] m_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = PCI; m_halted = 1'b0; m_q.delete();
        m_instr = '0; m_fpc = '0; m_npc = '0; m_valid = 1'b0;
    endtask

    task automatic model_bubble();
        m_instr = '0; m_valid = 1'b0;
    endtask

    task automatic model_step();
        bit          have;
        bit          holding;
        logic [63:0] w;
        if (m_halted) begin
            if (FDen || FDflush) model_bubble();
            return;
        end
        holding = (m_q.size() != 0);
        have    = holding || ihit;
        w       = holding ? m_q[0] : {imemload, m_pc};
        if (halt) begin
            m_halted = 1'b1; m_q.delete(); model_bubble();
        end else if (redirect) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_q.delete();
            if (FDen || FDflush) model_bubble();
        end else begin
            if (FDflush) model_bubble();
            else if (FDen) begin
                if (have) begin
                    m_instr = w[63:32]; m_fpc = w[31:0]; m_npc = w[31:0] + 32'd4; m_valid = 1'b1;
                end else model_bubble();
            end
            if (have) begin
                if (FDen) begin
                    if (holding) void'(m_q.pop_front());
                    else m_pc = m_pc + 32'd4;
                end else if (!holding) begin
                    m_q.push_back(w); m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] st;
        st = m_halted ? 32'd2 : (m_q.size() != 0 ? 32'd1 : 32'd0);
        chk({tag, ".state"},    32'(fetch_state), st);
        chk({tag, ".iREN"},     32'(iREN),        32'(st == 32'd0));
        chk({tag, ".imemaddr"}, imemaddr,         m_pc);
        chk({tag, ".instr"},    fd_instr,         m_instr);
        chk({tag, ".fd_pc"},    fd_pc,            m_fpc);
        chk({tag, ".fd_npc"},   fd_npc,           m_npc);
        chk({tag, ".valid"},    32'(fd_valid),    32'(m_valid));
    endtask

    task automatic cycle(input string tag, input bit ih, input bit en, input bit fl,
                         input bit rd, input bit ht, input logic [31:0] ld,
                         input logic [31:0] rpc);
        ihit = ih; FDen = en; FDflush = fl; redirect = rd; halt = ht;
        imemload = ld; redirect_pc = rpc;
        @(posedge CLK);
        model_step();
        #1 check_all(tag);
    endtask

    // Asynchronous reset applied between edges, with ihit high across an edge
    task automatic do_reset(input string tag);
        #2 nRST = 1'b0;
        ihit = 1'b1; imemload = 32'hDEAD_BEEF; FDen = 1'b1;
        model_reset();
        #1 check_all({tag, ".async"});
        chk({tag, ".addr_init"}, imemaddr, PCI);
        @(posedge CLK);
        #1 check_all({tag, ".held"});
        #2 nRST = 1'b1;
    endtask

    initial begin
        int halted_cycles;
        nRST = 1'b1; ihit = 0; FDen = 0; FDflush = 0; redirect = 0; halt = 0;
        imemload = '0; redirect_pc = '0;
        @(posedge CLK);
        do_reset("rst0");

        // Back-to-back fetches
        cycle("f0", 1, 1, 0, 0, 0, 32'hAAAA_0001, 0);
        cycle("f1", 1, 1, 0, 0, 0, 32'hBBBB_0002, 0);
        cycle("f2", 1, 1, 0, 0, 0, 32'hCCCC_0003, 0);
        chk("f2.addr12", imemaddr, 32'd12);
        chk("f2.pc8",    fd_pc,    32'd8);

        // Stall into HOLD at pc=8, then release
        cycle("rd8",  0, 0, 1, 1, 0, 0, 32'd8);
        cycle("hold", 1, 0, 0, 0, 0, 32'h1234_5678, 0);
        chk("hold.addr12", imemaddr, 32'd12);
        chk("hold.iren",   32'(iREN), 32'd0);
        cycle("rel",  0, 1, 0, 0, 0, 0, 0);
        chk("rel.pc8",   fd_pc,    32'd8);
        chk("rel.instr", fd_instr, 32'h1234_5678);

        // Redirect+flush while holding
        cycle("hold2", 1, 0, 0, 0, 0, 32'h5555_AAAA, 0);
        cycle("rdh",   1, 0, 1, 1, 0, 32'h6666_0000, 32'h0000_0103);
        chk("rdh.addr", imemaddr, 32'h100);

        // PC wrap
        cycle("rdw",  0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC);
        cycle("wrap", 1, 1, 0, 0, 0, 32'h7777_0007, 0);
        chk("wrap.npc",  fd_npc,   32'd0);
        chk("wrap.addr", imemaddr, 32'd0);

        // Reset mid-wait at pc=0x40
        cycle("rd40", 0, 0, 0, 1, 0, 0, 32'h40);
        cycle("wt0",  0, 1, 0, 0, 0, 0, 0);
        cycle("wt1",  0, 1, 0, 0, 0, 0, 0);
        do_reset("rst1");

        // Halt beats redirect and ihit; then nothing wakes it
        cycle("pre", 1, 1, 0, 0, 0, 32'h0101_0101, 0);
        cycle("hlt", 1, 1, 0, 1, 1, 32'h0202_0202, 32'h200);
        for (int i = 0; i < 6; i++)
            cycle("hz", 1, 1, i[0], 1, 0, $urandom, $urandom);
        do_reset("rst2");

        // Random traffic
        halted_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            cycle("rnd", $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8,
                  $urandom_range(0, 99) < 2, $urandom, $urandom);
            if (m_halted) halted_cycles++;
            if (halted_cycles > 8) begin
                do_reset("rstr");
                halted_cycles = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, named CLK and nRST.
REQ-003 SHALL have ports:
  CLK  input  1  system clock, rising edge.
  nRST  input  1  asynchronous active-low reset.
  ihit  input  1  icache data valid for the current imemaddr.
  imemload  input  32  instruction word from the icache.
  iREN  output  1  instruction read request.
  imemaddr  output  32  fetch address; equals the current PC.
  FDen  input  1  IF/ID latch enable from the hazard unit.
  FDflush  input  1  IF/ID latch flush from the hazard unit.
  redirect  input  1  taken branch or jump resolved downstream.
  redirect_pc  input  32  target of the redirect.
  halt  input  1  halt instruction detected downstream.
  fd_instr  output  32  IF/ID instruction; 0 is the NOP/bubble.
  fd_pc  output  32  PC of fd_instr.
  fd_npc  output  32  fd_pc+4.
  fd_valid  output  1  fd_instr holds a real instruction.
  fetch_state  output  2  current FSM state, for debug.

Function
REQ-004 SHALL implement FSM states FETCH, HOLD and HALTED.
REQ-005 FETCH: iREN=1, imemaddr=pc.
REQ-006 HOLD: iREN=0; one fetched instruction is in the internal buffer.
REQ-007 HALTED: iREN=0; imemaddr=pc, frozen.
REQ-008 Transfer condition: "instruction available" = (FETCH & ihit) | HOLD.
REQ-009 FETCH & ihit & FDen & !FDflush & !redirect & !halt: load fd_instr=imemload, fd_pc=pc, fd_npc=pc+4, fd_valid=1; pc<=pc+4; stay in FETCH.
REQ-010 FETCH & ihit & !FDen & !redirect & !halt: capture imemload and pc into the buffer; pc<=pc+4; go to HOLD.
REQ-011 HOLD & FDen & !FDflush & !redirect & !halt: load the fd registers from the buffer with fd_valid=1; go to FETCH.
REQ-012 FDen=1 with no instruction available and no flush: load a bubble (fd_instr=0, fd_valid=0, fd_pc/fd_npc unchanged).
REQ-013 FDen=0 and FDflush=0: fd registers hold their values.
REQ-014 FDflush=1: on the next edge, fd_instr=0 and fd_valid=0; flush beats FDen.
REQ-015 redirect=1 & !halt: pc<=redirect_pc with bits [1:0] forced to 00; discard the buffered instruction and any same-cycle ihit data; state<=FETCH; redirect beats ihit.
REQ-016 halt=1: state<=HALTED; fd registers load a bubble; pc is unchanged; halt beats redirect, FDflush and ihit.
REQ-017 HALTED SHALL be exited only by nRST.
REQ-018 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-019 imemaddr SHALL stay stable while iREN=1 and ihit=0.
REQ-020 The buffer holds at most one entry; a capture SHALL never occur in HOLD.
REQ-021 Fetch-to-latch latency SHALL be one edge after ihit when FDen=1.

Reset
REQ-022 nRST low SHALL immediately set: pc=PC_INIT, state=FETCH, buffer empty, fd_instr=0, fd_pc=0, fd_npc=0, fd_valid=0.
REQ-023 After reset, iREN=1 and imemaddr=PC_INIT.
REQ-024 An ihit coincident with reset assertion SHALL be dropped.

Structure
REQ-025 fetch_state_t (FETCH=2'b00, HOLD=2'b01, HALTED=2'b10) and word_t SHALL reside in cpu_types_pkg.
REQ-026 One sub-module, if_id_latch, SHALL hold the fd_* registers with en, flush and bubble controls.
REQ-027 The PC register, buffer and FSM SHALL reside in fetch_stage.

Verification
REQ-028 Reset, then ihit=1 and FDen=1 for 3 cycles with imemload=A,B,C -> fd_pc=0,4,8 with fd_valid=1; imemaddr=12.
REQ-029 At pc=8, ihit=1 and FDen=0 -> HOLD, iREN=0, imemaddr=12; then FDen=1 -> fd_pc=8, state FETCH.
REQ-030 In HOLD, redirect=1 with redirect_pc=32'h0000_0103 and FDflush=1 -> buffer dropped, fd_valid=0, imemaddr=32'h100.
REQ-031 halt=1, redirect=1 and ihit=1 in the same cycle -> HALTED, iREN=0, fd_valid=0; later pulses on ihit or redirect have no effect.
REQ-032 pc=32'hFFFF_FFFC, ihit=1, FDen=1 -> fd_npc=0, imemaddr=0.
REQ-033 nRST asserted mid-wait (iREN=1, ihit=0, pc=32'h40) -> all outputs at reset values before the next edge; imemaddr=PC_INIT.
